// File: rtl/apb_hub75_regs.sv
// apb_hub75_regs
// APB slave for the Hub75 cape. It holds the control and status registers,
// the BCM and pixels-per-row timing registers, and a write port into the
// frame-buffer RAM.
//
// The timing registers are double buffered. Software writes the shadow copy
// and then arms COMMIT. On the next frame_sync pulse every shadow copies to
// the live outputs together, so the display never sees a half-updated set
// of timings.
//
// Ports
//   pclk, presetn            APB clock; asynchronous active-low reset
//   psel/penable/pwrite      APB control
//   paddr                    byte address; the MSB selects registers (1)
//                            or the frame buffer (0)
//   pwdata/prdata            write data / registered read data
//   pready/pslverr           transfer complete / transfer error
//   frame_sync               one-cycle frame-start pulse
//   status_in                live status bits from the display pipeline
//   control                  control register; [2:1] is the pixel format
//   pixels_per_row           committed pixels per row
//   bcm_count                committed BCM counts; plane i is in
//                            [i*BCM_W +: BCM_W]
//   fb_wr/fb_data/fb_waddr   one-cycle pixel write strobe, RGB565 data and
//                            pixel address
//   fb_busy                  stalls pixel issue while high
//   irq                      level interrupt, irq_flag & irq_en
`timescale 1ns/1ps
module apb_hub75_regs #(
  parameter int ADDR_W      = 18,
  parameter int BCM_PLANES  = 6,
  parameter int BCM_W       = 12,
  parameter int PPR_W       = 10,
  parameter int FB_AW       = 15,
  parameter int DEFAULT_PPR = 64
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [ADDR_W-1:0]           paddr,
  input  logic [31:0]                 pwdata,
  output logic [31:0]                 prdata,
  output logic                        pready,
  output logic                        pslverr,
  input  logic                        frame_sync,
  input  logic [15:0]                 status_in,
  output logic [31:0]                 control,
  output logic [PPR_W-1:0]            pixels_per_row,
  output logic [BCM_PLANES*BCM_W-1:0] bcm_count,
  output logic                        fb_wr,
  output logic [15:0]                 fb_data,
  output logic [FB_AW-1:0]            fb_waddr,
  input  logic                        fb_busy,
  output logic                        irq
);

  localparam int          WORD_W      = ADDR_W - 3;
  localparam int          WA          = WORD_W + 1;
  localparam logic [31:0] ID_VALUE    = 32'h4875_0002;
  localparam logic [5:0]  OFF_ID      = 6'h00;
  localparam logic [5:0]  OFF_CONTROL = 6'h01;
  localparam logic [5:0]  OFF_PPR     = 6'h02;
  localparam logic [5:0]  OFF_STATUS  = 6'h03;
  localparam logic [5:0]  OFF_COMMIT  = 6'h04;
  localparam logic [5:0]  OFF_IRQ_EN  = 6'h05;
  localparam logic [5:0]  OFF_BCM_LO  = 6'h08;
  localparam logic [5:0]  OFF_BCM_HI  = 6'(8 + BCM_PLANES);

  typedef enum logic [1:0] {S_IDLE, S_PIX0, S_PIX1, S_ACK} fb_state_e;
  typedef enum logic [1:0] {
    FMT_ABGR   = 2'b00,
    FMT_RGB565 = 2'b01,
    FMT_PACKED = 2'b10,
    FMT_RSVD   = 2'b11
  } pix_fmt_e;

  // Reset value of BCM plane i: the plane weight times (DEFAULT_PPR + 6).
  function automatic logic [BCM_W-1:0] bcm_default(input int i);
    return BCM_W'((1 << i) * (DEFAULT_PPR + 6));
  endfunction

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic              reg_space;
  logic [5:0]        offset;
  logic [WORD_W-1:0] word_idx;
  logic              access_phase;
  logic              setup_read;
  logic              fb_write_req;
  logic              off_valid;
  logic              reg_err;
  logic              reg_write;

  assign reg_space    = paddr[ADDR_W-1];
  assign offset       = paddr[7:2];
  assign word_idx     = paddr[ADDR_W-2:2];
  assign access_phase = psel & penable;
  assign setup_read   = psel & ~penable & ~pwrite;
  assign fb_write_req = access_phase & pwrite & ~reg_space;
  assign off_valid    = (offset <= OFF_IRQ_EN) ||
                        ((offset >= OFF_BCM_LO) && (offset < OFF_BCM_HI));
  assign reg_err      = ~off_valid | (pwrite & (offset == OFF_ID));
  // A register write always completes in its first access cycle, so it is
  // applied on that edge.
  assign reg_write    = access_phase & pwrite & reg_space & ~reg_err;

  // ---------------------------------------------------------------------
  // Register file, shadows and commit
  // ---------------------------------------------------------------------
  logic [PPR_W-1:0] ppr_shadow;
  logic [BCM_W-1:0] bcm_shadow [BCM_PLANES];
  logic [BCM_W-1:0] bcm_live   [BCM_PLANES];
  logic             irq_en;
  logic             irq_flag;
  logic             commit_pending;
  logic             commit_fire;

  assign commit_fire = frame_sync & commit_pending;

  // NOTE: every flop here, the capture registers included, sits on the
  // asynchronous reset. The block holds no RAM arrays, so nothing is left
  // uninitialised coming out of reset.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      control        <= 32'h1;
      ppr_shadow     <= PPR_W'(DEFAULT_PPR);
      pixels_per_row <= PPR_W'(DEFAULT_PPR);
      for (int i = 0; i < BCM_PLANES; i++) begin
        bcm_shadow[i] <= bcm_default(i);
        bcm_live[i]   <= bcm_default(i);
      end
      irq_en         <= 1'b0;
      irq_flag       <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      // NOTE: with non-blocking assignment the commit copies the shadow
      // values from before this edge. A shadow write on the same edge is
      // therefore held until the next commit.
      if (commit_fire) begin
        pixels_per_row <= ppr_shadow;
        for (int i = 0; i < BCM_PLANES; i++) bcm_live[i] <= bcm_shadow[i];
      end

      if (reg_write) begin
        case (offset)
          OFF_CONTROL: control    <= pwdata;
          OFF_PPR:     ppr_shadow <= pwdata[PPR_W-1:0];
          OFF_IRQ_EN:  irq_en     <= pwdata[0];
          default:     ;
        endcase
      end
      for (int i = 0; i < BCM_PLANES; i++) begin
        if (reg_write && (offset == OFF_BCM_LO + 6'(i)))
          bcm_shadow[i] <= pwdata[BCM_W-1:0];
      end

      // frame_sync samples commit_pending as it was before this edge, so a
      // COMMIT written on the same edge waits for the next frame.
      if (reg_write && (offset == OFF_COMMIT) && pwdata[0])
        commit_pending <= 1'b1;
      else if (commit_fire)
        commit_pending <= 1'b0;

      // A commit setting the flag wins over a same-cycle write-1-to-clear.
      if (commit_fire)
        irq_flag <= 1'b1;
      else if (reg_write && (offset == OFF_STATUS) && pwdata[0])
        irq_flag <= 1'b0;
    end
  end

  for (genvar g = 0; g < BCM_PLANES; g++) begin : g_bcm_out
    assign bcm_count[g*BCM_W +: BCM_W] = bcm_live[g];
  end

  assign irq = irq_flag & irq_en;

  // ---------------------------------------------------------------------
  // Read path. prdata loads on the setup edge, so reads have no wait states.
  // ---------------------------------------------------------------------
  logic [31:0] rd_value;

  // NOTE: every always_comb gives each of its outputs a default first. No
  // path through the block is left unassigned, so no latch is inferred.
  always_comb begin
    rd_value = '0;
    if (reg_space && off_valid) begin
      case (offset)
        OFF_ID:      rd_value = ID_VALUE;
        OFF_CONTROL: rd_value = control;
        OFF_PPR:     rd_value = 32'(ppr_shadow);
        OFF_STATUS:  rd_value = {status_in, 14'b0, commit_pending, irq_flag};
        OFF_IRQ_EN:  rd_value = {31'b0, irq_en};
        default:     ;
      endcase
      for (int i = 0; i < BCM_PLANES; i++) begin
        if (offset == OFF_BCM_LO + 6'(i)) rd_value = 32'(bcm_shadow[i]);
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)        prdata <= '0;
    else if (setup_read) prdata <= rd_value;
  end

  // ---------------------------------------------------------------------
  // Frame-buffer write FSM
  // ---------------------------------------------------------------------
  fb_state_e         state, state_nxt;
  logic [31:0]       cap_data;
  logic [WORD_W-1:0] cap_word;
  pix_fmt_e          cap_fmt;
  logic              cap_err;
  logic              issue;
  logic              issue_hi;
  logic [15:0]       pix_data;
  logic [WA-1:0]     pix_addr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    issue_hi  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fb_write_req)
          state_nxt = (pix_fmt_e'(control[2:1]) == FMT_RSVD) ? S_ACK : S_PIX0;
      end
      S_PIX0: begin
        if (!fb_busy) begin
          issue     = 1'b1;
          state_nxt = (cap_fmt == FMT_PACKED) ? S_PIX1 : S_ACK;
        end
      end
      S_PIX1: begin
        if (!fb_busy) begin
          issue     = 1'b1;
          issue_hi  = 1'b1;
          state_nxt = S_ACK;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The pixel format is frozen at capture, so a CONTROL write during a
  // stalled transfer cannot change how the captured word is unpacked.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cap_data <= '0;
      cap_word <= '0;
      cap_fmt  <= FMT_ABGR;
      cap_err  <= 1'b0;
    end else if ((state == S_IDLE) && fb_write_req) begin
      cap_data <= pwdata;
      cap_word <= word_idx;
      cap_fmt  <= pix_fmt_e'(control[2:1]);
      cap_err  <= (pix_fmt_e'(control[2:1]) == FMT_RSVD);
    end
  end

  always_comb begin
    pix_data = cap_data[15:0];
    pix_addr = {1'b0, cap_word};
    case (cap_fmt)
      FMT_ABGR:   pix_data = {cap_data[23:19], cap_data[15:10], cap_data[7:3]};
      FMT_PACKED: begin
        pix_data = issue_hi ? cap_data[31:16] : cap_data[15:0];
        pix_addr = {cap_word, issue_hi};
      end
      default:    ;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      fb_wr    <= 1'b0;
      fb_data  <= '0;
      fb_waddr <= '0;
    end else begin
      fb_wr <= issue;
      if (issue) begin
        fb_data  <= pix_data;
        fb_waddr <= pix_addr[FB_AW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Handshake: only frame-buffer writes insert wait states.
  // ---------------------------------------------------------------------
  assign pready  = fb_write_req ? (state == S_ACK) : 1'b1;
  assign pslverr = access_phase &
                   (reg_space ? reg_err : (pwrite & (state == S_ACK) & cap_err));

  // The byte-lane bits and the bits of the packed address above the frame
  // buffer width are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], pix_addr[WA-1:FB_AW]};

endmodule
